// File: rtl/cga_vgaport.sv
// CGA-to-VGA output stage: turns the doubled IRGB stream and syncs into 6-bit RGB,
// polarity-adjusted syncs and DE. The outputs sit two registers behind the inputs.
module cga_vgaport #(
    parameter int unsigned H_START   = 192,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_START   = 76,
    parameter int unsigned V_ACTIVE  = 400,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter bit          BROWN_FIX = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dbl_video,
    input  logic       dbl_hsync,
    input  logic       vsync,
    output logic [5:0] vga_r,
    output logic [5:0] vga_g,
    output logic [5:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       vga_de
);

    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] V_LO = 11'(V_START);
    localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

    logic [3:0] video_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       hsync_prev_r;
    logic       vsync_prev_r;
    logic [9:0] hpix_r;
    logic [9:0] vline_r;

    logic       hrise_s;
    logic       vrise_s;
    logic [9:0] hpix_s;
    logic [9:0] vline_s;
    logic       de_s;
    logic [5:0] pal_r_s;
    logic [5:0] pal_g_s;
    logic [5:0] pal_b_s;

    // One palette channel: colour bit contributes 2/3 of full scale, intensity 1/3.
    function automatic logic [5:0] cga_level(input logic c, input logic i);
        logic [5:0] lvl;
        lvl = c ? 6'h2A : 6'h00;
        lvl = lvl + (i ? 6'h15 : 6'h00);
        return lvl;
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? 10'h3FF : v + 10'd1;
    endfunction

    // Counter next-state values belong to the sample currently in stage 1.
    always_comb begin
        hrise_s = hsync_r & ~hsync_prev_r;
        vrise_s = vsync_r & ~vsync_prev_r;
        hpix_s  = hrise_s ? 10'd0 : sat_inc(hpix_r);
        if (vrise_s) begin
            vline_s = 10'd0;
        end else if (hrise_s) begin
            vline_s = sat_inc(vline_r);
        end else begin
            vline_s = vline_r;
        end
        de_s = ({1'b0, hpix_s} >= H_LO) && ({1'b0, hpix_s} < H_HI) &&
               ({1'b0, vline_s} >= V_LO) && ({1'b0, vline_s} < V_HI);
        pal_r_s = cga_level(video_r[2], video_r[3]);
        pal_b_s = cga_level(video_r[0], video_r[3]);
        if (BROWN_FIX && (video_r == 4'b0110)) begin
            pal_g_s = 6'h15;
        end else begin
            pal_g_s = cga_level(video_r[1], video_r[3]);
        end
    end

    // Stage 1: input capture, edge history and position counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_r      <= 4'd0;
            hsync_r      <= 1'b0;
            vsync_r      <= 1'b0;
            hsync_prev_r <= 1'b0;
            vsync_prev_r <= 1'b0;
            hpix_r       <= 10'h3FF;
            vline_r      <= 10'h3FF;
        end else begin
            video_r      <= dbl_video;
            hsync_r      <= dbl_hsync;
            vsync_r      <= vsync;
            hsync_prev_r <= hsync_r;
            vsync_prev_r <= vsync_r;
            hpix_r       <= hpix_s;
            vline_r      <= vline_s;
        end
    end

    // Stage 2: blanked colour, polarity-adjusted syncs and DE, all aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r     <= 6'd0;
            vga_g     <= 6'd0;
            vga_b     <= 6'd0;
            vga_hsync <= ~HSYNC_POL;
            vga_vsync <= ~VSYNC_POL;
            vga_de    <= 1'b0;
        end else begin
            vga_r     <= de_s ? pal_r_s : 6'd0;
            vga_g     <= de_s ? pal_g_s : 6'd0;
            vga_b     <= de_s ? pal_b_s : 6'd0;
            vga_hsync <= ~(hsync_r ^ HSYNC_POL);
            vga_vsync <= ~(vsync_r ^ VSYNC_POL);
            vga_de    <= de_s;
        end
    end

endmodule

// File: tb/tb_cga_vgaport.sv
// Directed bench for cga_vgaport: default instance plus open-window and small-window variants.
module tb_cga_vgaport;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dbl_video = 4'd0;
    logic       dbl_hsync = 1'b0;
    logic       vsync = 1'b0;

    logic [5:0] d_r, d_g, d_b, a_r, a_g, a_b, b_r, b_g, b_b, f_r, f_g, f_b;
    logic       d_hs, d_vs, d_de, a_hs, a_vs, a_de, b_hs, b_vs, b_de, f_hs, f_vs, f_de;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cga_vgaport dut (
        .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_de(d_de)
    );

    cga_vgaport #(.H_START(0), .V_START(0), .BROWN_FIX(1'b1)) dut_a (
        .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_de(a_de)
    );

    cga_vgaport #(.H_START(0), .V_START(0), .BROWN_FIX(1'b0)) dut_b (
        .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_de(b_de)
    );

    cga_vgaport #(.H_START(2), .H_ACTIVE(4), .HSYNC_POL(1'b1)) dut_f (
        .clk(clk), .reset(reset), .dbl_video(dbl_video), .dbl_hsync(dbl_hsync), .vsync(vsync),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hsync(f_hs), .vga_vsync(f_vs), .vga_de(f_de)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        dbl_video = 4'd0;
        dbl_hsync = 1'b0;
        vsync = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic vsync_pulse();
        dbl_hsync = 1'b0;
        vsync = 1'b1;
        for (int i = 0; i < 4; i++) step();
        vsync = 1'b0;
        for (int i = 0; i < 2; i++) step();
    endtask

    task automatic short_lines(input int n);
        dbl_video = 4'hF;
        vsync = 1'b0;
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++) begin
                dbl_hsync = (k < 2);
                step();
            end
        end
    endtask

    // 912-cycle lines with hsync high on cycles 720..879; output at cycle t+1 reflects input t-1.
    task automatic full_lines(input int n, output int de_cnt, output int de_first,
                              output int hs_first, output int hs_cnt, output int blank_err);
        de_cnt = 0; de_first = -1; hs_first = -1; hs_cnt = 0; blank_err = 0;
        for (int t = 0; t < n * 912; t++) begin
            dbl_video = 4'hF;
            vsync = 1'b0;
            dbl_hsync = ((t % 912) >= 720) && ((t % 912) < 880);
            step();
            if (d_de === 1'b1) begin
                de_cnt++;
                if (de_first < 0) de_first = t + 1;
            end
            if ((d_hs === 1'b0) && (t + 1 < 1200)) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = t + 1;
            end
            if ({d_r, d_g, d_b} !== (d_de ? 18'h3FFFF : 18'h00000)) blank_err++;
        end
    endtask

    function automatic logic [17:0] exp_pal(input int i, input bit fix);
        case (i)
            0:  return {6'h00, 6'h00, 6'h00};
            1:  return {6'h00, 6'h00, 6'h2A};
            2:  return {6'h00, 6'h2A, 6'h00};
            3:  return {6'h00, 6'h2A, 6'h2A};
            4:  return {6'h2A, 6'h00, 6'h00};
            5:  return {6'h2A, 6'h00, 6'h2A};
            6:  return fix ? {6'h2A, 6'h15, 6'h00} : {6'h2A, 6'h2A, 6'h00};
            7:  return {6'h2A, 6'h2A, 6'h2A};
            8:  return {6'h15, 6'h15, 6'h15};
            9:  return {6'h15, 6'h15, 6'h3F};
            10: return {6'h15, 6'h3F, 6'h15};
            11: return {6'h15, 6'h3F, 6'h3F};
            12: return {6'h3F, 6'h15, 6'h15};
            13: return {6'h3F, 6'h15, 6'h3F};
            14: return {6'h3F, 6'h3F, 6'h15};
            15: return {6'h3F, 6'h3F, 6'h3F};
            default: return 18'h00000;
        endcase
    endfunction

    task automatic test_reset();
        dbl_video = 4'hF;
        dbl_hsync = 1'b1;
        vsync = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({d_r, d_g, d_b, d_de} !== 19'd0) begin
            bad++; $display("FAIL reset_rgb_de got=%h want=0", {d_r, d_g, d_b, d_de});
        end
        total++;
        if ({d_hs, d_vs, f_hs, f_vs} !== 4'b1101) begin
            bad++; $display("FAIL reset_syncs got=%b want=1101", {d_hs, d_vs, f_hs, f_vs});
        end
        step();
        total++;
        if ({d_r, d_g, d_b, d_de, d_hs, d_vs} !== {19'd0, 2'b11}) begin
            bad++; $display("FAIL reset_hold got=%h want=%h", {d_r, d_g, d_b, d_de, d_hs, d_vs}, {19'd0, 2'b11});
        end
        reset_pulse();
    endtask

    task automatic test_palette();
        reset_pulse();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        for (int i = 0; i <= 16; i++) begin
            dbl_video = 4'(i);
            dbl_hsync = (i < 2);
            step();
            if (i >= 1) begin
                total++;
                if ({a_r, a_g, a_b, a_de} !== {exp_pal(i - 1, 1'b1), 1'b1}) begin
                    bad++; $display("FAIL palette_fix irgb=%0d got=%h want=%h", i - 1, {a_r, a_g, a_b, a_de}, {exp_pal(i - 1, 1'b1), 1'b1});
                end
                total++;
                if ({b_r, b_g, b_b, b_de} !== {exp_pal(i - 1, 1'b0), 1'b1}) begin
                    bad++; $display("FAIL palette_nofix irgb=%0d got=%h want=%h", i - 1, {b_r, b_g, b_b, b_de}, {exp_pal(i - 1, 1'b0), 1'b1});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        reset_pulse();
        dbl_video = 4'hF;
        vsync = 1'b1;
        dbl_hsync = 1'b1;
        step();
        step();
        total++;
        if ({a_de, a_r, a_g, a_b} !== {1'b1, 18'h3FFFF}) begin
            bad++; $display("FAIL simul_edges_open got=%h want=%h", {a_de, a_r, a_g, a_b}, {1'b1, 18'h3FFFF});
        end
        total++;
        if (d_de !== 1'b0) begin
            bad++; $display("FAIL simul_edges_default_de got=%b want=0", d_de);
        end
        vsync = 1'b0;
        dbl_hsync = 1'b0;
        step();
    endtask

    task automatic test_line_and_mid_reset();
        int de_cnt, de_first, hs_first, hs_cnt, blank_err;
        reset_pulse();
        vsync_pulse();
        short_lines(75);
        full_lines(2, de_cnt, de_first, hs_first, hs_cnt, blank_err);
        total++;
        if (de_cnt !== 640) begin bad++; $display("FAIL line_de_count got=%0d want=640", de_cnt); end
        total++;
        if (de_first !== 914) begin bad++; $display("FAIL line_de_rise got=%0d want=914", de_first); end
        total++;
        if (hs_first !== 722) begin bad++; $display("FAIL line_hs_offset got=%0d want=722", hs_first); end
        total++;
        if (hs_cnt !== 160) begin bad++; $display("FAIL line_hs_width got=%0d want=160", hs_cnt); end
        total++;
        if (blank_err !== 0) begin bad++; $display("FAIL line_blanking got=%0d want=0", blank_err); end

        dbl_hsync = 1'b0;
        for (int i = 0; i < 200; i++) step();
        total++;
        if ({d_de, d_r} !== {1'b1, 6'h3F}) begin
            bad++; $display("FAIL midreset_active got=%h want=%h", {d_de, d_r}, {1'b1, 6'h3F});
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({d_r, d_g, d_b, d_de, d_hs, d_vs} !== {19'd0, 2'b11}) begin
            bad++; $display("FAIL midreset_async got=%h want=%h", {d_r, d_g, d_b, d_de, d_hs, d_vs}, {19'd0, 2'b11});
        end
        step();
        reset = 1'b0;
        full_lines(3, de_cnt, de_first, hs_first, hs_cnt, blank_err);
        total++;
        if (de_cnt !== 0) begin bad++; $display("FAIL midreset_no_vsync_de got=%0d want=0", de_cnt); end
        vsync_pulse();
        short_lines(75);
        full_lines(2, de_cnt, de_first, hs_first, hs_cnt, blank_err);
        total++;
        if (de_cnt !== 640) begin bad++; $display("FAIL midreset_resume_de got=%0d want=640", de_cnt); end
        total++;
        if (blank_err !== 0) begin bad++; $display("FAIL midreset_blanking got=%0d want=0", blank_err); end
    endtask

    task automatic test_frame();
        int de_lines = 0, first_line = -1, last_line = -1, bad_len = 0, vs_err = 0, blank_err = 0;
        logic vs_prev, hs_prev;
        reset_pulse();
        vs_prev = 1'b0;
        hs_prev = 1'b0;
        dbl_video = 4'hF;
        for (int j = 0; j <= 524; j++) begin
            int cnt = 0;
            for (int k = 0; k < 16; k++) begin
                if (j == 0) begin
                    vsync = (k >= 2) && (k < 6);
                    dbl_hsync = 1'b0;
                end else begin
                    vsync = 1'b0;
                    dbl_hsync = (k < 2);
                end
                step();
                if ((d_vs !== ~vs_prev) || (f_vs !== ~vs_prev) || (f_hs !== hs_prev)) vs_err++;
                if ({f_r, f_g, f_b} !== (f_de ? 18'h3FFFF : 18'h00000)) blank_err++;
                if (f_de === 1'b1) cnt++;
                vs_prev = vsync;
                hs_prev = dbl_hsync;
            end
            if (cnt != 0) begin
                de_lines++;
                if (first_line < 0) first_line = j;
                last_line = j;
            end
            if ((cnt != 0) && (cnt != 4)) bad_len++;
        end
        total++;
        if (de_lines !== 400) begin bad++; $display("FAIL frame_de_lines got=%0d want=400", de_lines); end
        total++;
        if (first_line !== 76) begin bad++; $display("FAIL frame_first_line got=%0d want=76", first_line); end
        total++;
        if (last_line !== 475) begin bad++; $display("FAIL frame_last_line got=%0d want=475", last_line); end
        total++;
        if (bad_len !== 0) begin bad++; $display("FAIL frame_de_width got=%0d want=0", bad_len); end
        total++;
        if (vs_err !== 0) begin bad++; $display("FAIL frame_sync_mirror got=%0d want=0", vs_err); end
        total++;
        if (blank_err !== 0) begin bad++; $display("FAIL frame_blanking got=%0d want=0", blank_err); end
    endtask

    initial begin
        test_reset();
        test_palette();
        test_simultaneous();
        test_line_and_mid_reset();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
